// File: rtl/cpu_phase_ctrl.sv
// cpu_phase_ctrl: handshake-aware, opcode-aware FETCH/DECODE/EXEC/WB sequencer
// for the teaching CPU. Stalls on mem_ready and aborts into HALT on a
// halt opcode or a memory wait timeout.
module cpu_phase_ctrl #(
    parameter int unsigned         OPC_W     = 4,
    parameter logic [OPC_W-1:0]    LOAD_OPC  = OPC_W'(4'h1),
    parameter logic [OPC_W-1:0]    STORE_OPC = OPC_W'(4'h2),
    parameter logic [OPC_W-1:0]    HALT_OPC  = OPC_W'(4'hF),
    parameter int unsigned         WAIT_MAX  = 8,
    parameter int unsigned         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [OPC_W-1:0] mem_opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_load,
    output logic             alu_en,
    output logic             rf_we,
    output logic             pc_en,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WC_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            r_state;
    logic [OPC_W-1:0]  r_op;
    logic [WC_W-1:0]   r_wait;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_alu_en;
    logic              r_rf_we;
    logic              r_pc_en;
    logic [3:0]        r_phase;
    logic              r_busy;
    logic              r_halted;

    state_t            w_next;
    logic [3:0]        w_phase_next;
    logic              w_is_mem_op;
    logic              w_wait_expired;
    logic              w_enter_wait;

    // Latched opcode is a memory instruction (LOAD or STORE)
    assign w_is_mem_op    = (r_op == LOAD_OPC) || (r_op == STORE_OPC);
    // Last permitted wait cycle has elapsed with no acknowledge
    assign w_wait_expired = (r_wait == WC_W'(WAIT_MAX - 1)) && !mem_ready;
    // Entering a request phase restarts the wait timer
    assign w_enter_wait   = (w_next != r_state) &&
                            ((w_next == S_FETCH) || ((w_next == S_EXEC) && w_is_mem_op));

    // Next-state selection and one-hot phase of the next state
    always_comb begin
        w_next       = r_state;
        w_phase_next = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)           w_next = S_DECODE;
                else if (w_wait_expired) w_next = S_HALT;
            end
            S_DECODE: begin
                w_next = (r_op == HALT_OPC) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (!w_is_mem_op || mem_ready) w_next = S_WB;
                else if (w_wait_expired)       w_next = S_HALT;
            end
            S_WB: begin
                w_next = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        case (w_next)
            S_FETCH:  w_phase_next = 4'b0001;
            S_DECODE: w_phase_next = 4'b0010;
            S_EXEC:   w_phase_next = 4'b0100;
            S_WB:     w_phase_next = 4'b1000;
            default:  w_phase_next = 4'b0000;
        endcase
    end

    // State register, datapath-side registers and registered Moore strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_wait    <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_alu_en  <= 1'b0;
            r_rf_we   <= 1'b0;
            r_pc_en   <= 1'b0;
            r_phase   <= 4'b0000;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_enter_wait) begin
                r_wait <= '0;
            end else if (r_mem_req && !mem_ready) begin
                r_wait <= r_wait + WC_W'(1);
            end

            if ((r_state == S_FETCH) && mem_ready) begin
                r_op <= mem_opcode;
            end

            if (r_mem_req && w_wait_expired) begin
                r_timeout <= 1'b1;
            end

            if (r_state == S_WB) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // r_op is stable whenever the next state is EXEC or WB
            r_mem_req <= (w_next == S_FETCH) || ((w_next == S_EXEC) && w_is_mem_op);
            r_mem_we  <= (w_next == S_EXEC) && (r_op == STORE_OPC);
            r_alu_en  <= (w_next == S_EXEC) && !w_is_mem_op;
            r_rf_we   <= (w_next == S_WB) && (r_op != STORE_OPC);
            r_pc_en   <= (w_next == S_WB);
            r_phase   <= w_phase_next;
            r_busy    <= (w_next != S_IDLE) && (w_next != S_HALT);
            r_halted  <= (w_next == S_HALT);
        end
    end

    // Instruction register load is a same-cycle response to the fetch acknowledge
    assign ir_load     = (r_state == S_FETCH) && mem_ready;

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign alu_en      = r_alu_en;
    assign rf_we       = r_rf_we;
    assign pc_en       = r_pc_en;
    assign phase       = r_phase;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign timeout_err = r_timeout;
    assign instr_count = r_cnt;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Scoreboard bench for cpu_phase_ctrl: a per-cycle reference model pushes the
// expected observable outputs; an independent monitor pops and compares.
module tb_cpu_phase_ctrl;

    localparam int unsigned WAIT_MAX = 8;
    localparam logic [3:0]  OP_LOAD  = 4'h1;
    localparam logic [3:0]  OP_STORE = 4'h2;
    localparam logic [3:0]  OP_HALT  = 4'hF;

    // model step names
    localparam int M_IDLE = 0, M_FETCH = 1, M_DEC = 2, M_EXEC = 3, M_WB = 4, M_HALT = 5;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        ir_load;
        logic        alu_en;
        logic        rf_we;
        logic        pc_en;
        logic [3:0]  phase;
        logic        busy;
        logic        halted;
        logic        timeout_err;
        logic [15:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [3:0]  mem_opcode = 4'h0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, ir_load, alu_en, rf_we, pc_en;
    logic [3:0]  phase;
    logic        busy, halted, timeout_err;
    logic [15:0] instr_count;

    obs_t exp_q[$];
    bit   started = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // reference model state
    int          m_st   = M_IDLE;
    logic [3:0]  m_op   = 4'h0;
    int          m_wait = 0;
    logic [15:0] m_cnt  = 16'h0;
    logic        m_to   = 1'b0;

    cpu_phase_ctrl #(
        .OPC_W(4), .LOAD_OPC(OP_LOAD), .STORE_OPC(OP_STORE), .HALT_OPC(OP_HALT),
        .WAIT_MAX(WAIT_MAX), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .mem_opcode(mem_opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_load(ir_load), .alu_en(alu_en),
        .rf_we(rf_we), .pc_en(pc_en), .phase(phase), .busy(busy), .halted(halted),
        .timeout_err(timeout_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, record the expected outputs, advance the model
    task automatic step(input logic r, input logic rn, input logic rdy, input logic [3:0] opc);
        obs_t e;
        bit   mem_instr;
        @(negedge clk);
        rst = r; run = rn; mem_ready = rdy; mem_opcode = opc;
        mem_instr     = (m_op == OP_LOAD) || (m_op == OP_STORE);
        e             = '0;
        e.mem_req     = (m_st == M_FETCH) || (m_st == M_EXEC && mem_instr);
        e.mem_we      = (m_st == M_EXEC) && (m_op == OP_STORE);
        e.ir_load     = (m_st == M_FETCH) && rdy;
        e.alu_en      = (m_st == M_EXEC) && !mem_instr;
        e.rf_we       = (m_st == M_WB) && (m_op != OP_STORE);
        e.pc_en       = (m_st == M_WB);
        e.phase       = (m_st >= M_FETCH && m_st <= M_WB) ? 4'(1 << (m_st - 1)) : 4'b0000;
        e.busy        = (m_st >= M_FETCH && m_st <= M_WB);
        e.halted      = (m_st == M_HALT);
        e.timeout_err = m_to;
        e.cnt         = m_cnt;
        exp_q.push_back(e);
        started = 1'b1;
        if (r) begin
            m_st = M_IDLE; m_op = 4'h0; m_wait = 0; m_cnt = 16'h0; m_to = 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (rn) begin m_st = M_FETCH; m_wait = 0; end
                M_FETCH, M_EXEC: begin
                    if (m_st == M_EXEC && !mem_instr) m_st = M_WB;
                    else if (rdy) begin
                        if (m_st == M_FETCH) begin m_op = opc; m_st = M_DEC; end
                        else m_st = M_WB;
                    end else if (m_wait == WAIT_MAX - 1) begin
                        m_to = 1'b1; m_st = M_HALT;
                    end else m_wait++;
                end
                M_DEC: if (m_op == OP_HALT) m_st = M_HALT;
                       else begin m_st = M_EXEC; m_wait = 0; end
                M_WB: begin
                    m_cnt  = m_cnt + 16'd1;
                    m_st   = rn ? M_FETCH : M_IDLE;
                    m_wait = 0;
                end
                default: ;
            endcase
        end
        cyc++;
    endtask

    // One instruction with given fetch/exec wait counts; run_x is run during EXEC/WB
    task automatic do_instr(input logic [3:0] opc, input int fw, input int ew,
                            input logic run_x, input bit rst_exec);
        int  pre;
        logic rdy, rn;
        for (int k = 0; k < 64; k++) begin
            pre = m_st;
            rn  = (m_st == M_EXEC || m_st == M_WB) ? run_x : 1'b1;
            if (m_st == M_FETCH)     rdy = (m_wait >= fw);
            else if (m_st == M_EXEC) rdy = (m_wait >= ew);
            else                     rdy = 1'($urandom % 2);
            if (rst_exec && m_st == M_EXEC) begin
                step(1'b1, rn, rdy, opc);
                return;
            end
            step(1'b0, rn, rdy, opc);
            if (pre == M_WB || m_st == M_HALT || m_st == M_IDLE) return;
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle
    always @(negedge clk) begin
        obs_t got, want;
        #2;
        if (started) begin
            got = '{mem_req, mem_we, ir_load, alu_en, rf_we, pc_en, phase,
                    busy, halted, timeout_err, instr_count};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty cycle=%0d got=%h want=<none>", cyc, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL outputs cycle=%0d got req/we/ir/alu/rf/pc=%b%b%b%b%b%b ph=%b busy=%b halt=%b to=%b cnt=%0d want %b%b%b%b%b%b ph=%b busy=%b halt=%b to=%b cnt=%0d",
                             cyc, got.mem_req, got.mem_we, got.ir_load, got.alu_en, got.rf_we, got.pc_en,
                             got.phase, got.busy, got.halted, got.timeout_err, got.cnt,
                             want.mem_req, want.mem_we, want.ir_load, want.alu_en, want.rf_we, want.pc_en,
                             want.phase, want.busy, want.halted, want.timeout_err, want.cnt);
                end
            end
        end
    end

    initial begin
        int   mode;
        int   halt_run;
        logic rdy;
        repeat (2) @(posedge clk);

        // reset state, then back-to-back ALU ops with immediate ready
        step(1'b1, 1'b0, 1'b0, 4'h0);
        repeat (4) do_instr(4'h3, 0, 0, 1'b1, 1'b0);
        // STORE with two exec wait cycles
        do_instr(OP_STORE, 0, 2, 1'b1, 1'b0);
        // LOAD with run dropped during EXEC, idle with stray ready, then resume
        do_instr(OP_LOAD, 1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b0, 1'b1, 4'h3);
        // ready arrives on the last permitted fetch wait cycle
        do_instr(4'h5, WAIT_MAX - 1, 0, 1'b1, 1'b0);
        // halt opcode, absorbing with run high, then reset
        do_instr(OP_HALT, 0, 0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b1, 1'b1, 4'h3);
        // fetch timeout
        do_instr(4'h3, WAIT_MAX, 0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        // exec timeout on a LOAD, then reset
        do_instr(OP_LOAD, 0, WAIT_MAX, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        // reset in EXEC while a STORE request is pending
        do_instr(4'h3, 0, 0, 1'b1, 1'b0);
        do_instr(OP_STORE, 0, 5, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'h0);

        // randomized traffic
        mode = 0;
        halt_run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 32 == 0) mode = int'($urandom % 3);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom % 2);
                default: rdy = ($urandom % 10) == 0;
            endcase
            halt_run = (m_st == M_HALT) ? halt_run + 1 : 0;
            step((halt_run > 3) || (($urandom % 200) == 0),
                 ($urandom % 8) != 0, rdy, 4'($urandom));
        end

        #3;
        started = 1'b0;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover got=%0d entries want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_phase_ctrl.md
Name: cpu_phase_ctrl

Overview:
Multi-cycle instruction sequencer for the teaching CPU. It walks the datapath through FETCH, DECODE, EXECUTE and WRITEBACK and issues the per-phase datapath strobes. It stalls on a memory ready handshake and aborts into HALT on a halt opcode or a memory timeout. It replaces the free-running 4-phase ring with a phase generator that is handshake-aware and opcode-aware.

Parameters:
OPC_W, 4, opcode width
LOAD_OPC, 4'h1, opcode of memory read instruction
STORE_OPC, 4'h2, opcode of memory write instruction
HALT_OPC, 4'hF, opcode that stops the sequencer
WAIT_MAX, 8, max cycles a memory request may wait for mem_ready (>=1)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
run  input  1  level; start or continue sequencing
mem_opcode  input  OPC_W  opcode field of fetched word; valid when mem_ready in FETCH
mem_ready  input  1  memory handshake acknowledge
mem_req  output  1  memory request
mem_we  output  1  memory write enable (qualifies mem_req)
ir_load  output  1  load instruction register
alu_en  output  1  ALU operation strobe
rf_we  output  1  register file write enable
pc_en  output  1  program counter increment
phase  output  4  one-hot phase: bit0 FETCH, bit1 DECODE, bit2 EXEC, bit3 WB
busy  output  1  state not IDLE and not HALT
halted  output  1  state is HALT
timeout_err  output  1  sticky; memory wait exceeded WAIT_MAX
instr_count  output  CNT_W  retired instructions

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE, op_reg=0, wait_cnt=0, instr_count=0, timeout_err=0. All strobes are 0. phase=4'b0000. busy=0, halted=0.
- rst wins over every other event. Asserting rst mid-instruction returns to IDLE on the next edge with no further strobes.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Encoding is free. phase is a Moore decode of state and is 0 in IDLE and HALT.
- IDLE: goes to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_we=0.
  - When mem_ready=1: ir_load=1 in the same cycle (Mealy), op_reg<=mem_opcode, go to DECODE.
  - Otherwise stay.
- DECODE: one cycle, no strobes.
  - op_reg==HALT_OPC -> HALT.
  - Otherwise -> EXEC.
- EXEC, ALU class (any opcode other than LOAD/STORE): alu_en=1 for exactly one cycle, then WB.
- EXEC, LOAD or STORE:
  - mem_req=1. mem_we=1 only for STORE.
  - Stay until mem_ready=1, then go to WB.
- WB:
  - One cycle. pc_en=1.
  - rf_we=1 for ALU class and LOAD; rf_we=0 for STORE.
  - instr_count increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE. Deasserting run never truncates an instruction in flight.
- Memory wait timer:
  - wait_cnt clears on entry to FETCH or memory EXEC.
  - It increments on each cycle with mem_req=1 and mem_ready=0.
  - If wait_cnt==WAIT_MAX-1 and mem_ready=0: timeout_err<=1 and go to HALT.
  - mem_ready in that same cycle wins; there is no timeout.
  - mem_ready=1 on the first request cycle gives zero wait.
- HALT: absorbing; only rst leaves it. All strobes are 0, halted=1.
- mem_ready outside a request is ignored.
- Latency with immediate mem_ready:
  - ALU or LOAD/STORE instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - HALT instruction: 2 cycles to HALT.

Test Plan:
1. Single ALU op:
   - Stimulus: rst, run=1, mem_ready=1 always, mem_opcode=4'h3.
   - Required: phase sequence 0001,0010,0100,1000 repeating; alu_en and rf_we/pc_en each one cycle per instruction; instr_count=3 after 12 cycles.
2. STORE with 2 wait cycles:
   - Stimulus: opcode 4'h2, mem_ready low 2 cycles in EXEC.
   - Required: EXEC lasts 3 cycles with mem_req=mem_we=1; WB has rf_we=0, pc_en=1.
3. HALT:
   - Stimulus: opcode 4'hF fetched.
   - Required: DECODE then halted=1, busy=0, phase=0; state stays put with run=1; rst returns to IDLE.
4. Timeout:
   - Stimulus: WAIT_MAX=8, mem_ready held 0 in FETCH.
   - Required: after 8 request cycles go to HALT, timeout_err=1.
   - Variant: mem_ready rises on 8th cycle -> no error, DECODE next.
5. run drop:
   - Stimulus: run=0 during EXEC of a LOAD.
   - Required: WB completes with rf_we=1, instr_count+1, then IDLE; run=1 resumes at FETCH.
6. Reset mid-op:
   - Stimulus: rst in EXEC with mem_req high.
   - Required: next cycle all strobes 0, phase=0, instr_count=0, timeout_err=0.
